// File: rtl/vdf_ctrl_pkg.sv
// Shared types and defaults for the VDF iteration controller.
package vdf_ctrl_pkg;

  localparam int DEF_MOD_LEN      = 1024;
  localparam int DEF_ITER_W       = 64;
  localparam int DEF_FLUSH_CYCLES = 4;
  localparam int DEF_WDOG_CYCLES  = 65536;

  // FLUSH_CYCLES is limited to 1..15, so four bits always hold the flush count.
  localparam int FLUSH_CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE,
    ST_FLUSH
  } ctrl_state_t;

  typedef logic [DEF_ITER_W-1:0] iter_t;

  function automatic int cnt_width(input int max_value);
    return (max_value < 1) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/vdf_flush_timer.sv
// Loadable down-counter; used for the flush hold time and, when compiled in,
// for the squarer watchdog.
module vdf_flush_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // Saturates at zero so a lingering dec cannot wrap the counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/vdf_iteration_ctrl.sv
// Sequences a free-running modular squarer through T squarings (x0^(2^T) mod N).
// Optional squarer watchdog: define VDF_CTRL_WATCHDOG_EN.
module vdf_iteration_ctrl
  import vdf_ctrl_pkg::*;
#(
  parameter int MOD_LEN      = DEF_MOD_LEN,
  parameter int ITER_W       = DEF_ITER_W,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
  parameter int WDOG_CYCLES  = DEF_WDOG_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [MOD_LEN-1:0] cmd_x0,
  input  logic [ITER_W-1:0]  cmd_iters,
  input  logic               abort,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [MOD_LEN-1:0] res_data,
  output logic [ITER_W-1:0]  res_iters,
  output logic               busy,
  output logic [ITER_W-1:0]  iter_cnt,
  output logic               error,
  output logic               sq_reset,
  output logic               sq_start,
  output logic [MOD_LEN-1:0] sq_in,
  input  logic [MOD_LEN-1:0] sq_out,
  input  logic               sq_valid
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  ctrl_state_t state, state_next;

  logic [ITER_W-1:0]  target;
  logic [ITER_W-1:0]  iter_cnt_q;
  logic [ITER_W-1:0]  iter_next;
  logic [ITER_W-1:0]  res_iters_q;
  logic [MOD_LEN-1:0] res_data_q;
  logic [MOD_LEN-1:0] sq_in_q;
  logic               sq_start_q;
  logic               state_idle;
  logic               flush_load;
  logic               flush_expired;
  logic               wdog_timeout;
  logic               reach_target;

  assign iter_next    = iter_cnt_q + ITER_W'(1);
  assign reach_target = sq_valid && (iter_next == target);

`ifdef VDF_CTRL_WATCHDOG_EN
  localparam int WDOG_W = cnt_width(WDOG_CYCLES);

  logic wdog_expired;
  logic error_q;

  // Reloaded whenever the squarer shows signs of life; only drains while waiting in RUN.
  vdf_flush_timer #(
    .WIDTH(WDOG_W)
  ) u_wdog_timer (
    .clk       (clk),
    .reset     (reset),
    .load      ((state == ST_LOAD) || sq_start_q || sq_valid),
    .load_value(WDOG_W'(WDOG_CYCLES)),
    .dec       (state == ST_RUN),
    .expired   (wdog_expired)
  );

  assign wdog_timeout = (state == ST_RUN) && wdog_expired && !sq_valid && !abort;

  always_ff @(posedge clk) begin
    if (reset) begin
      error_q <= 1'b0;
    end else if ((state == ST_IDLE) && cmd_valid) begin
      error_q <= 1'b0;
    end else if (wdog_timeout) begin
      error_q <= 1'b1;
    end
  end

  assign error = error_q;
`else
  logic unused_wdog;

  assign unused_wdog  = (WDOG_CYCLES != 0);
  assign wdog_timeout = 1'b0;
  assign error        = 1'b0;
`endif

  vdf_flush_timer #(
    .WIDTH(FLUSH_CNT_W)
  ) u_flush_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (flush_load),
    .load_value(FLUSH_LOAD),
    .dec       (state == ST_FLUSH),
    .expired   (flush_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Abort outranks a coincident sq_valid and the watchdog; DONE waits for the host regardless.
  always_comb begin
    state_next = state;
    state_idle = 1'b0;
    busy       = 1'b1;
    res_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        state_idle = 1'b1;
        busy       = 1'b0;
        if (cmd_valid) begin
          state_next = (cmd_iters == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_next = abort ? ST_FLUSH : ST_RUN;
      end
      ST_RUN: begin
        if (abort) begin
          state_next = ST_FLUSH;
        end else if (reach_target || wdog_timeout) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (flush_expired) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    flush_load = (state_next == ST_FLUSH) && (state != ST_FLUSH);
  end

  // The start pulse is registered off LOAD so the squarer sees a settled sq_in.
  always_ff @(posedge clk) begin
    if (reset) begin
      target      <= '0;
      iter_cnt_q  <= '0;
      res_iters_q <= '0;
      res_data_q  <= '0;
      sq_in_q     <= '0;
      sq_start_q  <= 1'b0;
    end else begin
      sq_start_q <= (state == ST_LOAD) && !abort;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            target     <= cmd_iters;
            iter_cnt_q <= '0;
            if (cmd_iters == '0) begin
              res_data_q  <= cmd_x0;
              res_iters_q <= '0;
            end else begin
              sq_in_q <= cmd_x0;
            end
          end
        end
        ST_LOAD: begin
          if (!abort) begin
            iter_cnt_q <= '0;
          end
        end
        ST_RUN: begin
          if (!abort) begin
            if (sq_valid) begin
              iter_cnt_q <= iter_next;
              res_data_q <= sq_out;
              if (reach_target) begin
                res_iters_q <= target;
              end
            end else if (wdog_timeout) begin
              res_iters_q <= iter_cnt_q;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign cmd_ready = state_idle && !reset;
  assign sq_reset  = reset || (state == ST_FLUSH);
  assign sq_start  = sq_start_q;
  assign sq_in     = sq_in_q;
  assign res_data  = res_data_q;
  assign res_iters = res_iters_q;
  assign iter_cnt  = iter_cnt_q;

endmodule

// File: tb/tb_vdf_iteration_ctrl.sv
// Scoreboard bench for vdf_iteration_ctrl with a 7-cycle squarer model (N = 1000003).
module tb_vdf_iteration_ctrl;
  import vdf_ctrl_pkg::*;

  localparam int MOD_LEN      = 64;
  localparam int ITER_W       = DEF_ITER_W;
  localparam int FLUSH_CYCLES = 4;
  localparam int WDOG_CYCLES  = 32;
  localparam int SQ_LAT       = 7;
  localparam logic [63:0] MODULUS = 64'd1000003;

  typedef struct packed {
    logic [63:0] data;
    logic [63:0] iters;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [MOD_LEN-1:0] cmd_x0 = '0;
  iter_t              cmd_iters = '0;
  logic               abort = 1'b0;
  logic               res_valid;
  logic               res_ready = 1'b0;
  logic [MOD_LEN-1:0] res_data;
  iter_t              res_iters;
  logic               busy;
  iter_t              iter_cnt;
  logic               error;
  logic               sq_reset;
  logic               sq_start;
  logic [MOD_LEN-1:0] sq_in;
  logic [MOD_LEN-1:0] sq_out = '0;
  logic               sq_valid = 1'b0;

  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  logic        model_active = 1'b0;
  logic [63:0] model_val = '0;
  int          model_timer = 0;
  int          pulse_cnt = 0;
  int          stall_after = 0;
  int          start_pulses = 0;

  vdf_iteration_ctrl #(
    .MOD_LEN     (MOD_LEN),
    .ITER_W      (ITER_W),
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .WDOG_CYCLES (WDOG_CYCLES)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_x0   (cmd_x0),
    .cmd_iters(cmd_iters),
    .abort    (abort),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .res_iters(res_iters),
    .busy     (busy),
    .iter_cnt (iter_cnt),
    .error    (error),
    .sq_reset (sq_reset),
    .sq_start (sq_start),
    .sq_in    (sq_in),
    .sq_out   (sq_out),
    .sq_valid (sq_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] sq_mod(input logic [63:0] v);
    return (v * v) % MODULUS;
  endfunction

  // Free-running squarer model: feeds back its own output until sq_reset.
  always @(posedge clk) begin
    if (sq_start === 1'b1) start_pulses <= start_pulses + 1;
    if (sq_reset !== 1'b0) begin
      model_active <= 1'b0;
      sq_valid     <= 1'b0;
      pulse_cnt    <= 0;
    end else if (sq_start === 1'b1) begin
      model_active <= 1'b1;
      model_val    <= sq_in;
      model_timer  <= SQ_LAT - 1;
      sq_valid     <= 1'b0;
      pulse_cnt    <= 0;
    end else if (model_active) begin
      if (stall_after != 0 && pulse_cnt >= stall_after) begin
        sq_valid <= 1'b0;
      end else if (model_timer == 0) begin
        sq_valid    <= 1'b1;
        sq_out      <= sq_mod(model_val);
        model_val   <= sq_mod(model_val);
        model_timer <= SQ_LAT - 1;
        pulse_cnt   <= pulse_cnt + 1;
      end else begin
        sq_valid    <= 1'b0;
        model_timer <= model_timer - 1;
      end
    end else begin
      sq_valid <= 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Result monitor: pops the scoreboard on every result handshake.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (reset === 1'b0 && res_valid === 1'b1 && res_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_result: actual data=%0h required=no result", res_data);
      end else begin
        e = exp_q.pop_front();
        checkOutput("sb_res_data", res_data, e.data);
        checkOutput("sb_res_iters", res_iters, e.iters);
      end
    end
  end

  // Returns at the first negedge after the accepting clock edge.
  task automatic applyStimulus(input logic [63:0] x0, input logic [63:0] iters);
    int w;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_x0    = x0;
    cmd_iters = iters;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    checkOutput("cmd_accepted", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic waitResult(input string name, input int bound);
    int w;
    w = 0;
    while (res_valid !== 1'b1 && w < bound) begin
      @(negedge clk);
      w++;
    end
    checkOutput({name, "_res_valid"}, 64'(res_valid), 64'd1);
  endtask

  task automatic pulseReady();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic checkFlush(input string name);
    int n;
    n = 0;
    while (sq_reset === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    checkOutput({name, "_flush_len"}, 64'(n), 64'(FLUSH_CYCLES));
    checkOutput({name, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: actual=running required=finished");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    int w;
    int s0;
    int bad;
    logic seen_res;

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_sq_reset", 64'(sq_reset), 64'd1);
    checkOutput("rst_outputs", 64'({res_valid, sq_start, error}), 64'd0);
    checkOutput("rst_iter_cnt", iter_cnt, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("post_rst_sq_reset", 64'(sq_reset), 64'd0);

    // x0=3, T=5: 3 -> 9 -> 81 -> 6561 -> 46592 -> 807954
    $display("[TB] basic job x0=3 T=5");
    exp_q.push_back('{64'd807954, 64'd5});
    applyStimulus(64'd3, 64'd5);
    checkOutput("t1_start_early", 64'(sq_start), 64'd0);
    @(negedge clk);
    checkOutput("t1_start_lat2", 64'(sq_start), 64'd1);
    @(negedge clk);
    checkOutput("t1_start_width", 64'(sq_start), 64'd0);
    waitResult("t1", 200);
    checkOutput("t1_pulses_at_done", 64'(pulse_cnt), 64'd5);
    checkOutput("t1_iter_cnt", iter_cnt, 64'd5);
    checkOutput("t1_busy", 64'(busy), 64'd1);
    pulseReady();
    checkOutput("t1_res_valid_drop", 64'(res_valid), 64'd0);
    checkFlush("t1");

    // T=0 returns x0 directly
    $display("[TB] zero-iteration job");
    s0 = start_pulses;
    exp_q.push_back('{64'h0ABC, 64'd0});
    applyStimulus(64'h0ABC, 64'd0);
    checkOutput("t2_res_valid_lat1", 64'(res_valid), 64'd1);
    checkOutput("t2_res_data", res_data, 64'h0ABC);
    pulseReady();
    checkFlush("t2");
    checkOutput("t2_no_start", 64'(start_pulses - s0), 64'd0);

    // Abort together with the 40th sq_valid
    $display("[TB] abort on 40th squaring");
    applyStimulus(64'd3, 64'd100);
    w = 0;
    seen_res = 1'b0;
    while (!(sq_valid === 1'b1 && pulse_cnt == 40) && w < 2000) begin
      if (res_valid === 1'b1) seen_res = 1'b1;
      @(negedge clk);
      w++;
    end
    checkOutput("t3_reached_40", 64'(pulse_cnt), 64'd40);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("t3_iter_cnt", iter_cnt, 64'd39);
    checkOutput("t3_no_result", 64'({seen_res, res_valid}), 64'd0);
    checkFlush("t3");
    checkOutput("t3_iter_hold", iter_cnt, 64'd39);

    // Back-pressure: 7 -> 49 -> 2401 -> 764786, squarer keeps pulsing
    $display("[TB] result back-pressure");
    exp_q.push_back('{64'd764786, 64'd3});
    applyStimulus(64'd7, 64'd3);
    waitResult("t4", 200);
    bad = 0;
    repeat (50) begin
      if (res_valid !== 1'b1 || res_data !== 64'd764786) bad++;
      @(negedge clk);
    end
    checkOutput("t4_stable", 64'(bad), 64'd0);
    checkOutput("t4_iters_hold", res_iters, 64'd3);
    pulseReady();
    checkOutput("t4_res_valid_drop", 64'(res_valid), 64'd0);
    checkFlush("t4");

    // Reset mid-RUN at iter_cnt=17, then 5 -> 25 -> 625
    $display("[TB] reset during run");
    applyStimulus(64'd3, 64'd100);
    w = 0;
    while (iter_cnt !== 64'd17 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    checkOutput("t5_reached_17", iter_cnt, 64'd17);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("t5_rst_sq_reset", 64'(sq_reset), 64'd1);
    checkOutput("t5_rst_ctrl", 64'({cmd_ready, busy, res_valid, sq_start, error}), 64'd0);
    checkOutput("t5_rst_iter_cnt", iter_cnt, 64'd0);
    checkOutput("t5_rst_data", res_data | sq_in | res_iters, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("t5_cmd_ready", 64'(cmd_ready), 64'd1);
    exp_q.push_back('{64'd625, 64'd2});
    applyStimulus(64'd5, 64'd2);
    waitResult("t5", 200);
    pulseReady();
    checkFlush("t5");

`ifdef VDF_CTRL_WATCHDOG_EN
    // Squarer stalls after 3 valids: 2 -> 4 -> 16 -> 256
    $display("[TB] watchdog on stalled squarer");
    stall_after = 3;
    exp_q.push_back('{64'd256, 64'd3});
    applyStimulus(64'd2, 64'd10);
    waitResult("t6", 400);
    checkOutput("t6_error", 64'(error), 64'd1);
    checkOutput("t6_res_iters", res_iters, 64'd3);
    pulseReady();
    stall_after = 0;
    checkFlush("t6");
    checkOutput("t6_error_sticky", 64'(error), 64'd1);
    exp_q.push_back('{64'd1, 64'd0});
    applyStimulus(64'd1, 64'd0);
    checkOutput("t6_error_cleared", 64'(error), 64'd0);
    pulseReady();
    checkFlush("t6b");
`else
    checkOutput("error_tied_low", 64'(error), 64'd0);
`endif

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
